ex_muldiv: RTL

- EX-stage multiply/divide unit with HI/LO registers.
- Sits directly downstream of the ID-stage funct generator. It consumes the 6-bit funct it produces for SPECIAL-opcode instructions: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Multiply completes in one extra cycle; divide is a 32-iteration restoring divider.
- Raises a stall to the pipeline control when a HI/LO-dependent instruction arrives while an operation is in flight.

---
 rtl/ex_muldiv_pkg.sv | 22 ++
 rtl/ex_muldiv_div_core.sv | 44 ++++
 rtl/ex_muldiv.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: funct codes, FSM state encoding and HI/LO-class decode for the EX mul/div unit.
package ex_muldiv_pkg;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam int MULDIV_STATE_BUS = 2;
  typedef enum logic [MULDIV_STATE_BUS-1:0] {
    MULDIV_IDLE,
    MULDIV_MUL,
    MULDIV_DIV,
    MULDIV_FIX
  } muldiv_state_e;
  function automatic logic is_hilo(input logic [5:0] f);
    return f inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                     FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction
endpackage

// File: rtl/ex_muldiv_div_core.sv
// muldiv_div_core: unsigned restoring divider, one quotient bit per step; done flags the last step.
module muldiv_div_core #(
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [ITERS-1:0] dividend,
  input  logic [ITERS-1:0] divisor,
  output logic [ITERS-1:0] quo,
  output logic [ITERS-1:0] rem,
  output logic             done
);
  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
  logic [ITERS-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ITERS:0] trial, diff;
  // The dividend is shifted out of quo_q's top while quotient bits enter at the bottom.
  always_comb begin
    trial = {rem_q, quo_q[ITERS-1]};
    diff = trial - {1'b0, dvs_q};
    quo_d = start ? dividend : step ? {quo_q[ITERS-2:0], ~diff[ITERS]} : quo_q;
    rem_d = start ? '0 : step ? (diff[ITERS] ? trial[ITERS-1:0] : diff[ITERS-1:0]) : rem_q;
    dvs_d = start ? divisor : dvs_q;
    cnt_d = start ? '0 : step ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  assign quo = quo_q;
  assign rem = rem_q;
  assign done = cnt_q == LAST;
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage MULT/DIV unit with HI/LO registers and HI/LO hazard stall.
// Define MULDIV_ITER_MUL_EN for a 32-step shift-add multiplier in place of the single-cycle product.
module ex_muldiv import ex_muldiv_pkg::*; #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  muldiv_state_e state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, abs_a, abs_b, quo, rem, fix_quo, fix_rem;
  logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic sgn, is_mul, is_div, accept, div_start, div_step, div_done;
`ifdef MULDIV_ITER_MUL_EN
  logic [63:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [4:0] mcnt_q, mcnt_d;
  logic mul_q, mul_d;
`else
  logic [63:0] prod_q, prod_d;
`endif
  assign is_mul = funct == FUNCT_MULT || funct == FUNCT_MULTU;
  assign is_div = funct == FUNCT_DIV || funct == FUNCT_DIVU;
  assign sgn = funct == FUNCT_MULT || funct == FUNCT_DIV;
  assign abs_a = sgn && op_a[31] ? -op_a : op_a;
  assign abs_b = sgn && op_b[31] ? -op_b : op_b;
  assign busy = state_q != MULDIV_IDLE;
  assign stall = valid & busy & is_hilo(funct);
  assign accept = valid & ~busy & ~flush & is_hilo(funct);
  assign rdata = funct == FUNCT_MFHI ? hi_q : funct == FUNCT_MFLO ? lo_q : '0;
  assign fix_quo = neg_quo_q ? -quo : quo;
  assign fix_rem = neg_rem_q ? -rem : rem;
  assign hi = hi_q;
  assign lo = lo_q;
  muldiv_div_core #(.ITERS(DIV_ITERS)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .step     (div_step),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quo      (quo),
    .rem      (rem),
    .done     (div_done)
  );
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div_start = 1'b0;
    div_step = 1'b0;
`ifdef MULDIV_ITER_MUL_EN
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    mcnt_d = mcnt_q;
    mul_d = mul_q;
`else
    prod_d = prod_q;
`endif
    if (flush) state_d = MULDIV_IDLE;
    else case (state_q)
      MULDIV_IDLE: if (accept) begin
        hi_d = funct == FUNCT_MTHI ? op_a : hi_q;
        lo_d = funct == FUNCT_MTLO ? op_a : lo_q;
        neg_quo_d = sgn & (op_a[31] ^ op_b[31]);
        neg_rem_d = sgn & op_a[31];
        div_start = is_div;
        state_d = is_div ? MULDIV_DIV : is_mul ? MULDIV_MUL : MULDIV_IDLE;
`ifdef MULDIV_ITER_MUL_EN
        acc_d = '0;
        mcand_d = {32'b0, abs_a};
        mplier_d = abs_b;
        mcnt_d = '0;
        mul_d = is_mul;
`else
        // Sign- or zero-extending to 64 bits makes the low 64 product bits correct for both forms.
        prod_d = {{32{sgn & op_a[31]}}, op_a} * {{32{sgn & op_b[31]}}, op_b};
`endif
      end
      MULDIV_MUL: begin
`ifdef MULDIV_ITER_MUL_EN
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        mcnt_d = mcnt_q + 5'd1;
        state_d = mcnt_q == 5'd31 ? MULDIV_FIX : MULDIV_MUL;
`else
        {hi_d, lo_d} = prod_q;
        state_d = MULDIV_IDLE;
`endif
      end
      MULDIV_DIV: begin
        div_step = 1'b1;
        state_d = div_done ? MULDIV_FIX : MULDIV_DIV;
      end
      default: begin
`ifdef MULDIV_ITER_MUL_EN
        {hi_d, lo_d} = mul_q ? (neg_quo_q ? -acc_q : acc_q) : {fix_rem, fix_quo};
`else
        {hi_d, lo_d} = {fix_rem, fix_quo};
`endif
        state_d = MULDIV_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= MULDIV_IDLE;
      hi_q <= '0;
      lo_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`ifdef MULDIV_ITER_MUL_EN
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      mcnt_q <= '0;
      mul_q <= 1'b0;
`else
      prod_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`ifdef MULDIV_ITER_MUL_EN
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      mcnt_q <= mcnt_d;
      mul_q <= mul_d;
`else
      prod_q <= prod_d;
`endif
    end
endmodule
